// File: rtl/onchip_ram_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_ram_arbiter
//
// Purpose:
//   Shares one single-port synchronous on-chip RAM between two masters.
//   The arbiter grants at most one master per cycle. Grants are combinational
//   from the arbiter state and the current requests. A master that keeps
//   requesting keeps ownership for up to MAX_RUN consecutive grants while the
//   other master is waiting. Reads return exactly one cycle after their grant.
//   Writes complete in their grant cycle.
//
// Parameters:
//   ADDR_W   word-address width of both masters and the RAM port
//   MAX_RUN  consecutive grants to one master while the other waits (1..15)
//
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   mN_address/byteenable/writedata   master N transfer payload
//   mN_read, mN_write                 master N requests (write wins if both)
//   mN_waitrequest                    high = master N request not accepted
//   mN_readdata, mN_readdatavalid     read return path (data shared by both)
//   ram_*                             single-port RAM drive, ram_readdata back
// ---------------------------------------------------------------------------
module onchip_ram_arbiter #(
    parameter int ADDR_W  = 14,
    parameter int MAX_RUN = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic [31:0]       ram_writedata,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic              ram_clken,
    input  logic [31:0]       ram_readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] MAX_RUN_L = 4'(MAX_RUN);

    state_t     r_state;
    logic [3:0] r_run;
    logic       r_lastOwner;
    logic       r_pend0;
    logic       r_pend1;

    logic       w_req0;
    logic       w_req1;
    logic       w_rawGrant0;
    logic       w_rawGrant1;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_runBelowMax;
    logic [3:0] w_runInc;

    assign w_req0        = m0_read | m0_write;
    assign w_req1        = m1_read | m1_write;
    assign w_runBelowMax = (r_run < MAX_RUN_L);
    assign w_runInc      = w_runBelowMax ? (r_run + 4'd1) : MAX_RUN_L;

    // Grant selection. The current owner keeps the RAM while it still
    // requests, unless the other master is waiting and the run limit is hit.
    always_comb begin
        w_rawGrant0 = 1'b0;
        w_rawGrant1 = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    // Tie goes to whoever did not own the RAM last
                    w_rawGrant0 = r_lastOwner;
                    w_rawGrant1 = ~r_lastOwner;
                end else begin
                    w_rawGrant0 = w_req0;
                    w_rawGrant1 = w_req1;
                end
            end
            OWN0: begin
                if (w_req0 && (!w_req1 || w_runBelowMax)) begin
                    w_rawGrant0 = 1'b1;
                end else begin
                    w_rawGrant1 = w_req1;
                end
            end
            OWN1: begin
                if (w_req1 && (!w_req0 || w_runBelowMax)) begin
                    w_rawGrant1 = 1'b1;
                end else begin
                    w_rawGrant0 = w_req0;
                end
            end
            default: begin
                w_rawGrant0 = 1'b0;
                w_rawGrant1 = 1'b0;
            end
        endcase
    end

    // Nothing is granted while reset is asserted.
    assign w_grant0 = w_rawGrant0 & reset_n;
    assign w_grant1 = w_rawGrant1 & reset_n;

    // Arbiter state, run counter, last owner and the read-pending tags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_run       <= 4'd0;
            r_lastOwner <= 1'b1;
            r_pend0     <= 1'b0;
            r_pend1     <= 1'b0;
        end else begin
            r_pend0 <= w_grant0 & m0_read & ~m0_write;
            r_pend1 <= w_grant1 & m1_read & ~m1_write;
            if (w_grant0) begin
                r_state     <= OWN0;
                r_lastOwner <= 1'b0;
                r_run       <= (r_state == OWN0) ? w_runInc : 4'd1;
            end else if (w_grant1) begin
                r_state     <= OWN1;
                r_lastOwner <= 1'b1;
                r_run       <= (r_state == OWN1) ? w_runInc : 4'd1;
            end else begin
                r_state <= IDLE;
                r_run   <= 4'd0;
            end
        end
    end

    assign m0_waitrequest = w_req0 & ~w_grant0;
    assign m1_waitrequest = w_req1 & ~w_grant1;

    // A pending read from before reset must not surface during reset
    assign m0_readdatavalid = r_pend0 & reset_n;
    assign m1_readdatavalid = r_pend1 & reset_n;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;

    assign ram_chipselect = w_grant0 | w_grant1;
    assign ram_write      = (w_grant0 & m0_write) | (w_grant1 & m1_write);
    assign ram_address    = w_grant1 ? m1_address    : m0_address;
    assign ram_byteenable = w_grant1 ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = w_grant1 ? m1_writedata  : m0_writedata;
    assign ram_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onchip_ram_arbiter
//
// Purpose:
//   Self-checking bench for onchip_ram_arbiter. A synchronous RAM model sits
//   on the RAM port. A reference model tracks owner, consecutive-grant count,
//   last owner, the outstanding read and the expected memory contents, and is
//   compared against the DUT on every falling clock edge. Directed scenarios
//   add literal expectations, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_onchip_ram_arbiter;

    localparam int ADDR_W  = 14;
    localparam int MAX_RUN = 4;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [3:0]        m0_byteenable, m1_byteenable;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [31:0]       m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [31:0]       m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] ram_address;
    logic [3:0]        ram_byteenable;
    logic [31:0]       ram_writedata;
    logic              ram_chipselect, ram_write, ram_clken;
    logic [31:0]       ram_readdata;

    int errors = 0;
    int checks = 0;

    onchip_ram_arbiter #(.ADDR_W(ADDR_W), .MAX_RUN(MAX_RUN)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .m0_address      (m0_address),
        .m0_byteenable   (m0_byteenable),
        .m0_read         (m0_read),
        .m0_write        (m0_write),
        .m0_writedata    (m0_writedata),
        .m0_waitrequest  (m0_waitrequest),
        .m0_readdata     (m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address      (m1_address),
        .m1_byteenable   (m1_byteenable),
        .m1_read         (m1_read),
        .m1_write        (m1_write),
        .m1_writedata    (m1_writedata),
        .m1_waitrequest  (m1_waitrequest),
        .m1_readdata     (m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address     (ram_address),
        .ram_byteenable  (ram_byteenable),
        .ram_writedata   (ram_writedata),
        .ram_chipselect  (ram_chipselect),
        .ram_write       (ram_write),
        .ram_clken       (ram_clken),
        .ram_readdata    (ram_readdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: registered read, byte-lane writes
    logic [31:0] ramMem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_chipselect && ram_clken) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) ramMem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
            end else begin
                ram_readdata <= ramMem[ram_address];
            end
        end
    end

    // Reference model state (what the RAM should hold and who should own it)
    logic [31:0] modelMem [0:DEPTH-1];
    int          ownerM  = -1;
    int          streakM = 0;
    int          lastM   = 1;
    int          pendM   = -1;
    logic [31:0] pendDataM;
    int          wait0   = 0;
    int          wait1   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(
        input logic rst,
        input logic r0, input logic w0, input logic [ADDR_W-1:0] a0, input logic [3:0] be0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic [ADDR_W-1:0] a1, input logic [3:0] be1, input logic [31:0] d1);
        reset_n       = rst;
        m0_read       = r0;  m0_write = w0;  m0_address = a0;
        m0_byteenable = be0; m0_writedata = d0;
        m1_read       = r1;  m1_write = w1;  m1_address = a1;
        m1_byteenable = be1; m1_writedata = d1;
    endtask

    // Per-cycle comparison against the reference model, then model update
    always @(negedge clk) begin
        logic              req0, req1;
        int                g;
        logic [ADDR_W-1:0] gAddr;
        logic              gWrite, gRead;
        logic [3:0]        gBe;
        logic [31:0]       gData;

        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;

        if (!reset_n)               g = -1;
        else if (req0 && !req1)     g = 0;
        else if (req1 && !req0)     g = 1;
        else if (!req0 && !req1)    g = -1;
        else if (ownerM < 0)        g = (lastM == 1) ? 0 : 1;
        else if (streakM < MAX_RUN) g = ownerM;
        else                        g = 1 - ownerM;

        gAddr  = (g == 1) ? m1_address    : m0_address;
        gBe    = (g == 1) ? m1_byteenable : m0_byteenable;
        gData  = (g == 1) ? m1_writedata  : m0_writedata;
        gWrite = (g == 1) ? m1_write : (g == 0) ? m0_write : 1'b0;
        gRead  = (g == 1) ? m1_read  : (g == 0) ? m0_read  : 1'b0;

        checkOutput("m0_waitrequest", 32'(m0_waitrequest), 32'(req0 && g != 0));
        checkOutput("m1_waitrequest", 32'(m1_waitrequest), 32'(req1 && g != 1));
        checkOutput("ram_chipselect", 32'(ram_chipselect), 32'(g >= 0));
        checkOutput("ram_write", 32'(ram_write), 32'(gWrite));
        checkOutput("ram_clken", 32'(ram_clken), 32'd1);
        if (g >= 0) begin
            checkOutput("ram_address", 32'(ram_address), 32'(gAddr));
            if (gWrite) begin
                checkOutput("ram_byteenable", 32'(ram_byteenable), 32'(gBe));
                checkOutput("ram_writedata", ram_writedata, gData);
            end
        end
        checkOutput("m0_readdatavalid", 32'(m0_readdatavalid), 32'(reset_n && pendM == 0));
        checkOutput("m1_readdatavalid", 32'(m1_readdatavalid), 32'(reset_n && pendM == 1));
        if (reset_n && pendM == 0) checkOutput("m0_readdata", m0_readdata, pendDataM);
        if (reset_n && pendM == 1) checkOutput("m1_readdata", m1_readdata, pendDataM);

        // A waiting master is never held off longer than the run limit
        wait0 = (reset_n && req0 && m0_waitrequest) ? wait0 + 1 : 0;
        wait1 = (reset_n && req1 && m1_waitrequest) ? wait1 + 1 : 0;
        checkOutput("m0_starvation", 32'(wait0 <= MAX_RUN), 32'd1);
        checkOutput("m1_starvation", 32'(wait1 <= MAX_RUN), 32'd1);

        if (!reset_n) begin
            ownerM = -1; streakM = 0; lastM = 1; pendM = -1;
        end else begin
            pendM = (g >= 0 && gRead && !gWrite) ? g : -1;
            if (g >= 0) begin
                pendDataM = modelMem[gAddr];
                if (gWrite)
                    for (int b = 0; b < 4; b++)
                        if (gBe[b]) modelMem[gAddr][b*8 +: 8] = gData[b*8 +: 8];
                streakM = (g == ownerM) ? ((streakM < MAX_RUN) ? streakM + 1 : MAX_RUN) : 1;
                ownerM  = g;
                lastM   = g;
            end else begin
                ownerM = -1; streakM = 0;
            end
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        int pattern [10];
        int granted;
        int waited;
        logic r0, w0, r1, w1;

        pattern = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

        for (int i = 0; i < DEPTH; i++) begin
            ramMem[i]   = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
            modelMem[i] = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
        end
        ramMem[14'h0010]   = 32'hDEAD_BEEF;
        modelMem[14'h0010] = 32'hDEAD_BEEF;
        ramMem[14'h3FFF]   = 32'hAABB_CCDD;
        modelMem[14'h3FFF] = 32'hAABB_CCDD;
        ram_readdata = 32'h0;

        // Reset holds off all grants even with requests present
        applyStimulus(0, 1, 0, 14'h1, 4'hF, 0, 0, 1, 14'h2, 4'hF, 32'h1);
        @(negedge clk);
        checkOutput("reset_m0_wait", 32'(m0_waitrequest), 32'd1);
        checkOutput("reset_m1_wait", 32'(m1_waitrequest), 32'd1);
        checkOutput("reset_chipselect", 32'(ram_chipselect), 32'd0);
        checkOutput("reset_ram_write", 32'(ram_write), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("idle_m0_wait", 32'(m0_waitrequest), 32'd0);
        tick();

        // Single read of 0x0010
        applyStimulus(1, 1, 0, 14'h0010, 4'hF, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rd10_wait", 32'(m0_waitrequest), 32'd0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rd10_valid", 32'(m0_readdatavalid), 32'd1);
        checkOutput("rd10_data", m0_readdata, 32'hDEAD_BEEF);
        tick();

        // Byte-lane write by m1 then readback by m0
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 14'h3FFF, 4'b0011, 32'h1234_5678);
        @(negedge clk);
        checkOutput("wr3fff_wait", 32'(m1_waitrequest), 32'd0);
        tick();
        applyStimulus(1, 1, 0, 14'h3FFF, 4'hF, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rd3fff_wait", 32'(m0_waitrequest), 32'd0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rd3fff_valid", 32'(m0_readdatavalid), 32'd1);
        checkOutput("rd3fff_data", m0_readdata, 32'hAABB_5678);
        tick();

        // Read and write together is a write with no response
        applyStimulus(1, 1, 1, 14'h0020, 4'hF, 32'hCAFE_F00D, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rw_ram_write", 32'(ram_write), 32'd1);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rw_no_valid", 32'(m0_readdatavalid), 32'd0);
        tick();

        // Continuous reads from both masters right after reset
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 0, 14'(i), 4'hF, 0, 1, 0, 14'(16'h0100 + i), 4'hF, 0);
            @(negedge clk);
            granted = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : -1);
            checkOutput($sformatf("pattern_%0d", i), 32'(granted), 32'(pattern[i]));
            tick();
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Reset right after an m1 read grant suppresses its response
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 14'h5, 4'hF, 0);
        @(negedge clk);
        checkOutput("rst_m1_granted", 32'(m1_waitrequest), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 14'h5, 4'hF, 0);
        @(negedge clk);
        checkOutput("rst_m1_valid", 32'(m1_readdatavalid), 32'd0);
        tick();
        applyStimulus(1, 1, 0, 14'h6, 4'hF, 0, 1, 0, 14'h7, 4'hF, 0);
        @(negedge clk);
        checkOutput("rst_tie_m0", 32'(m0_waitrequest), 32'd0);
        checkOutput("rst_tie_m1", 32'(m1_waitrequest), 32'd1);
        checkOutput("rst_m1_valid2", 32'(m1_readdatavalid), 32'd0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // m1 alone for ten cycles, then m0 joins and must get in quickly
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 14'(i + 32), 4'hF, 0);
            @(negedge clk);
            checkOutput("m1_alone", 32'(m1_waitrequest), 32'd0);
            tick();
        end
        waited = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, 0, 14'h40, 4'hF, 0, 1, 0, 14'h41, 4'hF, 0);
            @(negedge clk);
            if (!m0_waitrequest) break;
            waited++;
            tick();
        end
        checkOutput("m0_join_wait", 32'(waited), 32'd0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r0 = 1'($urandom_range(0, 1));
            w0 = ($urandom_range(0, 3) == 0);
            r1 = 1'($urandom_range(0, 1));
            w1 = ($urandom_range(0, 3) == 0);
            applyStimulus(($urandom_range(0, 63) != 0),
                          r0, w0, 14'($urandom_range(0, 31)), 4'($urandom), $urandom,
                          r1, w1, 14'($urandom_range(0, 31)), 4'($urandom), $urandom);
            tick();
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/onchip_ram_arbiter.md
ONCHIP_RAM_ARBITER -- requirements
Module: onchip_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, 14, word-address width shared by both masters and the RAM port.
REQ-002 Parameter MAX_RUN, 4, maximum consecutive grants to one master while the other is requesting; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 m0_address, m1_address  input  ADDR_W  word address from master 0 / master 1.
REQ-006 m0_byteenable, m1_byteenable  input  4  byte lanes for writes.
REQ-007 m0_read, m1_read, m0_write, m1_write  input  1 each  transfer requests; held until accepted.
REQ-008 m0_writedata, m1_writedata  input  32  write data.
REQ-009 m0_waitrequest, m1_waitrequest  output  1 each  high = request not accepted this cycle.
REQ-010 m0_readdata, m1_readdata, m0_readdatavalid, m1_readdatavalid  output  32/1  returned read data and its qualifier.
REQ-011 ram_address  output  ADDR_W;  ram_byteenable  output  4;  ram_writedata  output  32;  ram_chipselect, ram_write, ram_clken  output  1 each  single-port RAM drive.
REQ-012 ram_readdata  input  32  unregistered RAM output, valid one clk after the address edge.

Function
REQ-013 Request per master: reqN = mN_read | mN_write; when both are high, the transfer is a write and no readdatavalid follows.
REQ-014 FSM states: IDLE, OWN0, OWN1; plus a run counter (4 bits) and a last-owner bit.
REQ-015 Grant is combinational from state and requests: exactly one or zero masters granted per cycle.
REQ-016 IDLE: only one requesting -> grant it; both requesting -> grant the master that is not last-owner (after reset, master 0).
REQ-017 OWNn: reqn high and (other idle or run < MAX_RUN) -> grant n again; otherwise, if other requesting, grant other; if neither requesting, no grant.
REQ-018 State update: grant to master n -> next state OWNn and last-owner = n; run = 1 on an ownership change, run + 1 on a repeat grant, saturating at MAX_RUN; no grant -> IDLE, run = 0.
REQ-019 mN_waitrequest = reqN & ~grantN; an idle master sees waitrequest low.
REQ-020 In a grant cycle, ram_chipselect = 1, and ram_address, ram_byteenable, ram_writedata and ram_write = mN_write are muxed from the granted master; with no grant, ram_chipselect = 0, ram_write = 0 and the other RAM outputs are don't-care.
REQ-021 ram_clken is constant 1.
REQ-022 Read pipeline: a granted read sets a registered pending flag tagged with master n; the next cycle drives mn_readdatavalid = 1 and mn_readdata = ram_readdata; fixed latency 1 cycle.
REQ-023 Back-to-back reads, including reads that alternate between masters, are accepted every cycle, giving one readdatavalid per cycle with the correct tag.
REQ-024 Both mN_readdata ports carry ram_readdata continuously; only readdatavalid qualifies the data.
REQ-025 A write completes in its grant cycle; it produces no response.
REQ-026 Throughput: 1 transfer per cycle while any request is present; no idle cycle inserted on an ownership switch.
REQ-027 A master that has been denied is granted within MAX_RUN cycles of its request rising.

Reset
REQ-028 While reset_n = 0 at a clk edge: state = IDLE, run = 0, last-owner = 1 (so master 0 wins the first tie), read pending flags cleared.
REQ-029 Outputs during reset: both readdatavalid = 0, ram_chipselect = 0, ram_write = 0, waitrequest = reqN (no grants).
REQ-030 A read granted in the cycle in which reset_n is sampled low produces no readdatavalid.

Verification
REQ-031 m0 read only at address 0x0010, with RAM word 0x0010 = 0xDEADBEEF -> m0_waitrequest low the same cycle; m0_readdatavalid = 1 with 0xDEADBEEF the next cycle.
REQ-032 Both masters issue continuous reads with MAX_RUN = 4 from reset -> grant pattern 0,0,0,0,1,1,1,1,0...; every readdatavalid carries the correct tag; no gaps.
REQ-033 m1 writes 0x12345678 with byteenable 4'b0011 to 0x3FFF, then m0 reads 0x3FFF -> read returns the upper 16 bits of the previous contents and lower 16 bits = 0x5678.
REQ-034 m0 asserts read and write together -> write performed, no m0_readdatavalid.
REQ-035 reset_n is driven low in the cycle an m1 read is granted -> m1_readdatavalid stays 0; after release, state is IDLE and a simultaneous request is granted to m0.
REQ-036 m1 requests alone for 10 cycles, then m0 joins -> m0 is granted within 4 cycles and neither master is ever granted in the same cycle as the other.
